// File: rtl/pwm_gen.sv
// PWM generator: IDLE/RUN/STOP/BRAKE FSM, free-running period counter, duty latched per period.
// Define PWM_SLEW_EN to limit the per-period duty change to SLEW_STEP.
module pwm_gen #(
  parameter int CNT_W     = 11,
  parameter int SLEW_STEP = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             brake,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm_high,
  output logic             pwm_low,
  output logic             pwm_synch,
  output logic [CNT_W-1:0] duty_active,
  output logic             running
);

  typedef enum logic [1:0] {IDLE, RUN, STOP, BRAKE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, nextState;
  logic [CNT_W-1:0] cnt, nextCnt, nextDuty, loadDuty;
  logic             nextRun, nextHigh, nextLow, nextSynch;

`ifdef PWM_SLEW_EN
  localparam logic [CNT_W-1:0] STEP = CNT_W'(SLEW_STEP);

  // Move toward duty by at most STEP; the compare-before-add keeps it from wrapping.
  always_comb begin
    loadDuty = duty;
    if (duty > duty_active) begin
      if (duty - duty_active > STEP) loadDuty = duty_active + STEP;
    end else if (duty_active - duty > STEP) begin
      loadDuty = duty_active - STEP;
    end
  end
`else
  assign loadDuty = duty;
`endif

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    case (state)
      IDLE: begin
        if (en) nextState = RUN;
        nextCnt = '0;
      end
      RUN: begin
        nextState = en ? RUN : STOP;
        nextCnt   = cnt + CNT_W'(1);
      end
      STOP: begin
        nextCnt = cnt + CNT_W'(1);
        if (en) begin
          nextState = RUN;
        end else if (cnt == CNT_MAX) begin
          nextState = IDLE;
          nextCnt   = '0;
        end
      end
      default: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
    endcase
    if (brake) begin
      nextState = BRAKE;
      nextCnt   = '0;
    end
  end

  // Outputs are computed from next-cycle state so the registered values line up with cnt.
  always_comb begin
    nextRun   = (nextState == RUN) || (nextState == STOP);
    nextDuty  = '0;
    if (nextRun) nextDuty = (nextCnt == '0) ? loadDuty : duty_active;
    nextHigh  = nextRun && (nextCnt < nextDuty);
    nextLow   = (nextState == BRAKE) || (nextRun && !nextHigh);
    nextSynch = nextRun && (nextCnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      duty_active <= '0;
      pwm_high    <= 1'b0;
      pwm_low     <= 1'b0;
      pwm_synch   <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= nextState;
      cnt         <= nextCnt;
      duty_active <= nextDuty;
      pwm_high    <= nextHigh;
      pwm_low     <= nextLow;
      pwm_synch   <= nextSynch;
      running     <= nextRun;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: directed scenarios plus randomized run against a reference model.
module tb_pwm_gen;
  localparam int CNT_W = 11;
  localparam int PER   = 1 << CNT_W;
  localparam int MAXC  = PER - 1;
  localparam int STEP  = 64;
  localparam int S_IDLE = 0, S_RUN = 1, S_STOP = 2, S_BRAKE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0, en = 1'b0, brake = 1'b0;
  logic [CNT_W-1:0] duty = '0, duty_active;
  logic pwm_high, pwm_low, pwm_synch, running;
  logic [CNT_W+3:0] dutVec;

  int checks = 0, failures = 0;
  int mSt = S_IDLE, mCnt = 0, mDa = 0;

  pwm_gen #(.CNT_W(CNT_W), .SLEW_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .brake(brake), .duty(duty),
    .pwm_high(pwm_high), .pwm_low(pwm_low), .pwm_synch(pwm_synch),
    .duty_active(duty_active), .running(running)
  );

  always #5 clk = ~clk;
  assign dutVec = {pwm_high, pwm_low, pwm_synch, running, duty_active};

  function automatic int newDuty();
    int d = int'(duty);
`ifdef PWM_SLEW_EN
    if (d > mDa + STEP) return mDa + STEP;
    if (d < mDa - STEP) return mDa - STEP;
`endif
    return d;
  endfunction

  function automatic logic [CNT_W+3:0] expVec();
    logic act, hi;
    act = (mSt == S_RUN) || (mSt == S_STOP);
    hi  = act && (mCnt < mDa);
    return {hi, (mSt == S_BRAKE) || (act && !hi), act && (mCnt == 0), act, mDa[CNT_W-1:0]};
  endfunction

  // One clock: the model consumes the inputs seen at the edge, then outputs settle.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      mSt = S_IDLE; mCnt = 0; mDa = 0;
    end else if (brake) begin
      mSt = S_BRAKE; mCnt = 0; mDa = 0;
    end else begin
      case (mSt)
        S_IDLE:  if (en) begin mSt = S_RUN; mCnt = 0; mDa = newDuty(); end
        S_BRAKE: mSt = S_IDLE;
        default: begin
          if (mSt == S_STOP && !en && mCnt == MAXC) begin
            mSt = S_IDLE; mCnt = 0; mDa = 0;
          end else begin
            mSt  = en ? S_RUN : S_STOP;
            mCnt = (mCnt + 1) % PER;
            if (mCnt == 0) mDa = newDuty();
          end
        end
      endcase
    end
    #1;
  endtask

  task automatic go_idle();
    brake = 1'b1; tick();
    brake = 1'b0; en = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; duty = 11'd300;
    tick(); tick();
    checks++;
    if (dutVec !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", dutVec); end
    rst_n = 1'b1; en = 1'b0;
    tick();
    checks++;
    if (dutVec !== expVec()) begin failures++; $display("FAIL reset_release got=%h exp=%h", dutVec, expVec()); end
  endtask

  task automatic test_basic();
    int hi, lo;
    go_idle();
    duty = 11'd512; en = 1'b1;
    tick();
    for (int p = 0; p < 2; p++) begin
      hi = 0; lo = 0;
      for (int k = 0; k < PER; k++) begin
        checks++;
        if (dutVec !== expVec()) begin failures++; $display("FAIL basic_model k=%0d got=%h exp=%h", k, dutVec, expVec()); end
        checks++;
        if (pwm_synch !== (k == 0)) begin failures++; $display("FAIL basic_synch k=%0d got=%b exp=%b", k, pwm_synch, k == 0); end
        hi += int'(pwm_high); lo += int'(pwm_low);
        tick();
      end
      checks++;
      if (hi !== 512 || lo !== 1536) begin failures++; $display("FAIL basic_counts got=%0d/%0d exp=512/1536", hi, lo); end
    end
  endtask

  task automatic test_mid_change();
    int hi;
`ifdef PWM_SLEW_EN
    int expNext = 576;
`else
    int expNext = 1024;
`endif
    hi = 0;
    for (int k = 0; k < PER; k++) begin
      checks++;
      if (dutVec !== expVec()) begin failures++; $display("FAIL midchg_model k=%0d got=%h exp=%h", k, dutVec, expVec()); end
      hi += int'(pwm_high);
      if (k == 100) duty = 11'd1024;
      tick();
    end
    checks++;
    if (hi !== 512) begin failures++; $display("FAIL midchg_cur got=%0d exp=512", hi); end
    hi = 0;
    for (int k = 0; k < PER; k++) begin
      hi += int'(pwm_high);
      tick();
    end
    checks++;
    if (hi !== expNext) begin failures++; $display("FAIL midchg_next got=%0d exp=%0d", hi, expNext); end
  endtask

  task automatic test_en_drop();
    int n, guard;
    guard = 0;
    while (mCnt != 300 && guard < PER + 2) begin tick(); guard++; end
    checks++;
    if (running !== 1'b1 || mCnt != 300) begin failures++; $display("FAIL endrop_reach running=%b cnt=%0d exp=1/300", running, mCnt); end
    en = 1'b0;
    n = 0;
    while (running === 1'b1 && n < 3000) begin
      tick(); n++;
      checks++;
      if (dutVec !== expVec()) begin failures++; $display("FAIL endrop_model n=%0d got=%h exp=%h", n, dutVec, expVec()); end
    end
    checks++;
    if (n !== 1748) begin failures++; $display("FAIL endrop_len got=%0d exp=1748", n); end
    checks++;
    if ({pwm_high, pwm_low, running} !== 3'b000) begin failures++; $display("FAIL endrop_idle got=%b exp=000", {pwm_high, pwm_low, running}); end
  endtask

  task automatic test_brake();
    int guard;
    go_idle();
    duty = 11'd1000; en = 1'b1;
    tick();
    guard = 0;
    while (mCnt != 700 && guard < PER) begin tick(); guard++; end
    brake = 1'b1;
    tick();
    checks++;
    if ({pwm_high, pwm_low, running, duty_active} !== {3'b010, 11'd0}) begin
      failures++; $display("FAIL brake_drive got=%b exp=010 da=0", {pwm_high, pwm_low, running, duty_active});
    end
    brake = 1'b0;
    tick();
    checks++;
    if ({pwm_high, pwm_low, running} !== 3'b000) begin failures++; $display("FAIL brake_to_idle got=%b exp=000", {pwm_high, pwm_low, running}); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (running !== 1'b0) begin failures++; $display("FAIL brake_stay_idle i=%0d got=%b exp=0", i, running); end
    end
    en = 1'b1;
    tick();
    checks++;
    if ({running, pwm_synch} !== 2'b11) begin failures++; $display("FAIL brake_restart got=%b exp=11", {running, pwm_synch}); end
  endtask

  task automatic test_slew();
    int expTab[4];
`ifdef PWM_SLEW_EN
    expTab = '{64, 128, 192, 200};
`else
    expTab = '{200, 200, 200, 200};
`endif
    go_idle();
    duty = 11'd200; en = 1'b1;
    tick();
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (pwm_synch !== 1'b1 || int'(duty_active) !== expTab[p]) begin
        failures++; $display("FAIL slew p=%0d got=%0d synch=%b exp=%0d", p, duty_active, pwm_synch, expTab[p]);
      end
      repeat (PER) tick();
    end
  endtask

  task automatic test_duty_edges();
    int hi, lo, both;
`ifdef PWM_SLEW_EN
    int expLo = PER - STEP;
`else
    int expLo = 1;
`endif
    go_idle();
    duty = '0; en = 1'b1;
    tick();
    hi = 0; both = 0;
    repeat (2 * PER) begin
      hi += int'(pwm_high); both += int'(pwm_high & pwm_low);
      tick();
    end
    checks++;
    if (hi !== 0 || both !== 0) begin failures++; $display("FAIL duty0 high=%0d both=%0d exp=0/0", hi, both); end
    go_idle();
    duty = 11'(MAXC); en = 1'b1;
    tick();
    lo = 0; both = 0;
    repeat (PER) begin
      lo += int'(pwm_low); both += int'(pwm_high & pwm_low);
      tick();
    end
    checks++;
    if (lo !== expLo || both !== 0) begin failures++; $display("FAIL dutymax low=%0d both=%0d exp=%0d/0", lo, both, expLo); end
  endtask

  task automatic test_reset_mid();
    go_idle();
    duty = 11'($urandom_range(1, MAXC)); en = 1'b1;
    tick();
    repeat (500) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (dutVec !== '0) begin failures++; $display("FAIL rstmid_async got=%h exp=0", dutVec); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (dutVec !== expVec() || pwm_synch !== 1'b1) begin failures++; $display("FAIL rstmid_restart got=%h exp=%h", dutVec, expVec()); end
  endtask

  task automatic test_random();
    go_idle();
    en = 1'b1;
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 3))
          0:       duty = '0;
          1:       duty = 11'(MAXC);
          default: duty = 11'($urandom_range(0, MAXC));
        endcase
      end
      if ($urandom_range(0, 1499) == 0) en = ~en;
      brake = ($urandom_range(0, 2999) == 0);
      tick();
      checks++;
      if (dutVec !== expVec() || (pwm_high & pwm_low)) begin
        failures++; $display("FAIL random i=%0d got=%h exp=%h", i, dutVec, expVec());
      end
    end
    brake = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_change();
    test_en_drop();
    test_brake();
    test_slew();
    test_duty_edges();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
